// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_mouse_pkg;

  // Packet assembly state: which byte of the packet is expected next.
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } pkt_state_t;

  // Bit positions inside the first (header) byte of a mouse packet.
  localparam int L    = 0;
  localparam int R    = 1;
  localparam int M    = 2;
  localparam int SYNC = 3;
  localparam int XS   = 4;
  localparam int YS   = 5;
  localparam int XO   = 6;
  localparam int YO   = 7;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 receive path: synchronise and de-glitch ps2_c/ps2_d, deserialise 11-bit frames, check framing.
// Latency: byte strobe one cycle after the filtered falling edge that samples the stop bit.
// Backpressure: none; the PS/2 device cannot be stalled, so bytes are strobed out unconditionally.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_ps2_c/i_ps2_d raw pins;
//        i_busy high while a packet is partially assembled; o_byte_data/o_byte_valid/o_byte_err
//        received byte and its good/bad strobes; o_timeout one-cycle pulse on mid-frame/packet idle.
module ps2_rx_byte
  import ps2_mouse_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_c,
  input  logic       i_ps2_d,
  input  logic       i_busy,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic       o_byte_err,
  output logic       o_timeout
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic [1:0]       r_c_sync;
  logic [1:0]       r_d_sync;
  logic             r_c_flt;
  logic [FLT_W-1:0] r_flt_cnt;
  logic [3:0]       r_bit_cnt;
  logic [9:0]       r_shift;
  logic [TO_W-1:0]  r_to_cnt;
  logic [7:0]       r_byte;
  logic             r_byte_vld;
  logic             r_byte_err;

  logic w_c_s;
  logic w_d_s;
  logic w_fall;
  logic w_active;
  logic w_timeout;
  logic w_frame_ok;

  assign w_c_s = r_c_sync[1];
  assign w_d_s = r_d_sync[1];

  // The filtered clock flips on the FILTER_LEN-th consecutive sample that disagrees with it;
  // a falling edge is that flip while the filtered clock is currently high.
  assign w_fall = r_c_flt && !w_c_s && (r_flt_cnt == FLT_LAST);

  // r_shift holds bits 0..9 once the stop bit arrives: [0] start, [8:1] data, [9] parity.
  assign w_frame_ok = !r_shift[0] && (^r_shift[9:1]) && w_d_s;

  assign w_active  = (r_bit_cnt != 4'd0) || i_busy;
  assign w_timeout = w_active && !w_fall && (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c_sync  <= 2'b11;
      r_d_sync  <= 2'b11;
      r_c_flt   <= 1'b1;
      r_flt_cnt <= '0;
    end else begin
      r_c_sync <= {r_c_sync[0], i_ps2_c};
      r_d_sync <= {r_d_sync[0], i_ps2_d};
      if (w_c_s == r_c_flt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FLT_LAST) begin
        r_c_flt   <= w_c_s;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_byte     <= 8'h00;
      r_byte_vld <= 1'b0;
      r_byte_err <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_byte_err <= 1'b0;
      if (w_fall) begin
        if (r_bit_cnt == BIT_LAST) begin
          r_byte     <= r_shift[8:1];
          r_byte_vld <= w_frame_ok;
          r_byte_err <= !w_frame_ok;
          r_bit_cnt  <= 4'd0;
        end else begin
          r_shift   <= {w_d_s, r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (w_timeout) begin
        r_bit_cnt <= 4'd0;
      end
    end
  end

  // Idle watchdog: restarted by every bit, only advances while something is half-received.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if (w_fall || w_timeout) begin
      r_to_cnt <= '0;
    end else if (w_active) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign o_byte_data  = r_byte;
  assign o_byte_valid = r_byte_vld;
  assign o_byte_err   = r_byte_err;
  assign o_timeout    = w_timeout;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse front end: assembles 3-byte (or 4-byte wheel) packets and tracks a clamped cursor.
// Latency: outputs and pkt_valid update one cycle after the final byte strobe of a packet.
// Backpressure: none; every complete packet is applied immediately.
// Ports: clk/rst clock and async active-low reset; ps2_c/ps2_d raw PS/2 pins;
//        XMouseVGA/YMouseVGA cursor position; Botones {M,R,L}; wheel signed delta;
//        pkt_valid one-cycle update pulse; frame_err one-cycle bad-frame pulse.
module ps2_mouse_tracker
  import ps2_mouse_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int WHEEL_EN    = 0,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_c,
  input  logic               ps2_d,
  output logic [COORD_W-1:0] XMouseVGA,
  output logic [COORD_W-1:0] YMouseVGA,
  output logic [2:0]         Botones,
  output logic [3:0]         wheel,
  output logic               pkt_valid,
  output logic               frame_err
);

  localparam logic signed [COORD_W+1:0] XMAX_S = (COORD_W+2)'(X_MAX);
  localparam logic signed [COORD_W+1:0] YMAX_S = (COORD_W+2)'(Y_MAX);

  logic [7:0] w_byte;
  logic       w_byte_vld;
  logic       w_byte_err;
  logic       w_timeout;
  logic       w_busy;

  pkt_state_t r_state;
  pkt_state_t w_state_nxt;
  logic       w_cap0;
  logic       w_cap1;
  logic       w_cap2;
  logic       w_update;

  logic [2:0]         r_hdr_btn;
  logic               r_hdr_xs;
  logic               r_hdr_ys;
  logic               r_hdr_xo;
  logic               r_hdr_yo;
  logic [7:0]         r_b1;
  logic [7:0]         r_b2;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [2:0]         r_btn;
  logic [3:0]         r_wheel;
  logic               r_pkt_vld;

  logic [7:0]                 w_b2;
  logic signed [COORD_W+1:0]  w_dx;
  logic signed [COORD_W+1:0]  w_dy;
  logic signed [COORD_W+1:0]  w_x_sum;
  logic signed [COORD_W+1:0]  w_y_sum;

  assign w_busy = (r_state != B0);

  ps2_rx_byte #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_ps2_c      (ps2_c),
    .i_ps2_d      (ps2_d),
    .i_busy       (w_busy),
    .o_byte_data  (w_byte),
    .o_byte_valid (w_byte_vld),
    .o_byte_err   (w_byte_err),
    .o_timeout    (w_timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= B0;
    else      r_state <= w_state_nxt;
  end

  // A good byte takes priority over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cap0      = 1'b0;
    w_cap1      = 1'b0;
    w_cap2      = 1'b0;
    w_update    = 1'b0;
    if (w_byte_err) begin
      w_state_nxt = B0;
    end else if (w_byte_vld) begin
      case (r_state)
        B0: begin
          // Header bytes always have bit 3 set; anything else is a stray byte while resyncing.
          if (w_byte[SYNC]) begin
            w_cap0      = 1'b1;
            w_state_nxt = B1;
          end
        end
        B1: begin
          w_cap1      = 1'b1;
          w_state_nxt = B2;
        end
        B2: begin
          if (WHEEL_EN != 0) begin
            w_cap2      = 1'b1;
            w_state_nxt = B3;
          end else begin
            w_update    = 1'b1;
            w_state_nxt = B0;
          end
        end
        default: begin
          w_update    = 1'b1;
          w_state_nxt = B0;
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = B0;
    end
  end

  // The y byte is the byte arriving now for 3-byte packets, the stored one when a wheel byte follows.
  assign w_b2 = (WHEEL_EN != 0) ? r_b2 : w_byte;

  assign w_dx = r_hdr_xo ? '0 : {{(COORD_W-7){r_hdr_xs}}, r_hdr_xs, r_b1};
  assign w_dy = r_hdr_yo ? '0 : {{(COORD_W-7){r_hdr_ys}}, r_hdr_ys, w_b2};

  // Screen y grows downward while PS/2 +y means up, hence the subtraction.
  assign w_x_sum = $signed({2'b00, r_x}) + w_dx;
  assign w_y_sum = $signed({2'b00, r_y}) - w_dy;

  function automatic logic [COORD_W-1:0] f_clamp(input logic signed [COORD_W+1:0] v,
                                                 input logic signed [COORD_W+1:0] vmax);
    logic [COORD_W-1:0] res;
    if (v[COORD_W+1])  res = '0;
    else if (v > vmax) res = vmax[COORD_W-1:0];
    else               res = v[COORD_W-1:0];
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hdr_btn <= 3'b000;
      r_hdr_xs  <= 1'b0;
      r_hdr_ys  <= 1'b0;
      r_hdr_xo  <= 1'b0;
      r_hdr_yo  <= 1'b0;
      r_b1      <= 8'h00;
      r_b2      <= 8'h00;
      r_x       <= COORD_W'(X_INIT);
      r_y       <= COORD_W'(Y_INIT);
      r_btn     <= 3'b000;
      r_wheel   <= 4'h0;
      r_pkt_vld <= 1'b0;
    end else begin
      r_pkt_vld <= w_update;
      if (w_cap0) begin
        r_hdr_btn <= {w_byte[M], w_byte[R], w_byte[L]};
        r_hdr_xs  <= w_byte[XS];
        r_hdr_ys  <= w_byte[YS];
        r_hdr_xo  <= w_byte[XO];
        r_hdr_yo  <= w_byte[YO];
      end
      if (w_cap1) r_b1 <= w_byte;
      if (w_cap2) r_b2 <= w_byte;
      if (w_update) begin
        r_x     <= f_clamp(w_x_sum, XMAX_S);
        r_y     <= f_clamp(w_y_sum, YMAX_S);
        r_btn   <= r_hdr_btn;
        r_wheel <= (WHEEL_EN != 0) ? w_byte[3:0] : 4'h0;
      end
    end
  end

  assign XMouseVGA = r_x;
  assign YMouseVGA = r_y;
  assign Botones   = r_btn;
  assign wheel     = r_wheel;
  assign pkt_valid = r_pkt_vld;
  assign frame_err = w_byte_err;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: a 3-byte instance and a wheel instance, each on its own PS/2 lines.
module tb_ps2_mouse_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       c0, d0, c1, d1;
  logic [9:0] x0, y0, x1, y1;
  logic [2:0] b0, b1;
  logic [3:0] w0, w1;
  logic       pv0, fe0, pv1, fe1;

  ps2_mouse_tracker #(.WHEEL_EN(0), .TIMEOUT_CYC(1000)) dut0 (
    .clk(clk), .rst(rst), .ps2_c(c0), .ps2_d(d0),
    .XMouseVGA(x0), .YMouseVGA(y0), .Botones(b0), .wheel(w0),
    .pkt_valid(pv0), .frame_err(fe0)
  );

  ps2_mouse_tracker #(.WHEEL_EN(1), .TIMEOUT_CYC(1000)) dut1 (
    .clk(clk), .rst(rst), .ps2_c(c1), .ps2_d(d1),
    .XMouseVGA(x1), .YMouseVGA(y1), .Botones(b1), .wheel(w1),
    .pkt_valid(pv1), .frame_err(fe1)
  );

  typedef struct {
    int x;
    int y;
    int b;
    int w;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int pv0_cnt = 0;
  int pv1_cnt = 0;
  int fe0_cnt = 0;
  logic strb0_d = 1'b0;
  logic strb1_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every pkt_valid pulse must match the oldest queued expectation and
  // must come exactly one cycle after a byte strobe.
  always @(negedge clk) begin
    exp_t e;
    if (pv0 === 1'b1) begin
      pv0_cnt++;
      check("pkt0_expected", 32'(q0.size() != 0), 32'd1);
      check("pkt0_latency", 32'(strb0_d), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("x0", 32'(x0), e.x);
        check("y0", 32'(y0), e.y);
        check("btn0", 32'(b0), e.b);
        check("wheel0", 32'(w0), e.w);
      end
    end
    if (pv1 === 1'b1) begin
      pv1_cnt++;
      check("pkt1_expected", 32'(q1.size() != 0), 32'd1);
      check("pkt1_latency", 32'(strb1_d), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("x1", 32'(x1), e.x);
        check("y1", 32'(y1), e.y);
        check("btn1", 32'(b1), e.b);
        check("wheel1", 32'(w1), e.w);
      end
    end
    if (fe0 === 1'b1) fe0_cnt++;
    strb0_d = dut0.w_byte_vld;
    strb1_d = dut1.w_byte_vld;
  end

  task automatic set_line(input int which, input logic c, input logic d);
    if (which == 0) begin c0 = c; d0 = d; end
    else            begin c1 = c; d1 = d; end
  endtask

  // Device-side frame: data changes while clock is high, host samples on the falling edge.
  task automatic send_frame(input int which, input logic [7:0] data, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); set_line(which, 1'b1, f[i]);
      repeat (10) @(negedge clk); set_line(which, 1'b0, f[i]);
      repeat (20) @(negedge clk); set_line(which, 1'b1, f[i]);
      repeat (10) @(negedge clk);
    end
    @(negedge clk); set_line(which, 1'b1, 1'b1);
    repeat (60) @(negedge clk);
  endtask

  task automatic send3(input int which, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_frame(which, a, 1'b0, 11);
    send_frame(which, b, 1'b0, 11);
    send_frame(which, c, 1'b0, 11);
  endtask

  task automatic push0(input int x, input int y, input int b);
    exp_t e;
    e.x = x; e.y = y; e.b = b; e.w = 0;
    q0.push_back(e);
  endtask

  task automatic drain(input string tag, input int which);
    for (int i = 0; i < 300; i++) begin
      if ((which == 0 ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    check(tag, 32'(which == 0 ? q0.size() : q1.size()), 32'd0);
  endtask

  initial begin
    int exp_pv0;
    int fe_before;
    exp_t e;
    exp_pv0 = 0;
    rst = 1'b0;
    c0 = 1'b1; d0 = 1'b1; c1 = 1'b1; d1 = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_x", 32'(x0), 32'd320);
    check("rst_y", 32'(y0), 32'd240);
    check("rst_btn", 32'(b0), 32'd0);
    check("rst_wheel", 32'(w0), 32'd0);
    check("rst_pv", 32'(pv0), 32'd0);
    check("rst_fe", 32'(fe0), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Basic packet, then a reset landing mid-frame must restore the initial state.
    push0(330, 235, 1); exp_pv0++;
    send3(0, 8'h09, 8'h0A, 8'h05);
    drain("drain_basic_a", 0);
    send_frame(0, 8'h09, 1'b0, 5);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_x", 32'(x0), 32'd320);
    check("midrst_y", 32'(y0), 32'd240);
    check("midrst_btn", 32'(b0), 32'd0);
    check("midrst_pkts", 32'(pv0_cnt), 32'(exp_pv0));

    push0(330, 235, 1); exp_pv0++;
    send3(0, 8'h09, 8'h0A, 8'h05);
    drain("drain_basic_b", 0);

    // Negative x to the left edge, then x overflow suppresses x only.
    push0(74, 235, 0); exp_pv0++;
    send3(0, 8'h18, 8'h00, 8'h00);
    push0(0, 235, 0); exp_pv0++;
    send3(0, 8'h18, 8'h00, 8'h00);
    push0(0, 219, 0); exp_pv0++;
    send3(0, 8'h48, 8'h7F, 8'h10);
    drain("drain_clamp", 0);

    // Bad parity on byte 1 aborts the packet.
    fe_before = fe0_cnt;
    send_frame(0, 8'h08, 1'b0, 11);
    send_frame(0, 8'h0A, 1'b1, 11);
    check("ferr_pulse", 32'(fe0_cnt), 32'(fe_before + 1));
    check("ferr_noupd", 32'(pv0_cnt), 32'(exp_pv0));
    check("ferr_x", 32'(x0), 32'd0);
    push0(1, 219, 0); exp_pv0++;
    send3(0, 8'h08, 8'h01, 8'h00);
    drain("drain_ferr", 0);

    // Stray byte, then a half packet abandoned by timeout.
    send_frame(0, 8'h00, 1'b0, 11);
    send_frame(0, 8'h09, 1'b0, 11);
    send_frame(0, 8'h0A, 1'b0, 11);
    repeat (1500) @(negedge clk);
    check("timeout_noupd", 32'(pv0_cnt), 32'(exp_pv0));
    push0(3, 219, 0); exp_pv0++;
    send3(0, 8'h08, 8'h02, 8'h00);
    drain("drain_resync", 0);

    // Downward motion to the bottom edge, then rightward to the right edge.
    push0(3, 475, 0); exp_pv0++;
    send3(0, 8'h28, 8'h00, 8'h00);
    push0(3, 479, 0); exp_pv0++;
    send3(0, 8'h28, 8'h00, 8'h00);
    push0(258, 479, 0); exp_pv0++;
    send3(0, 8'h08, 8'hFF, 8'h00);
    push0(513, 479, 0); exp_pv0++;
    send3(0, 8'h08, 8'hFF, 8'h00);
    push0(639, 479, 4); exp_pv0++;
    send3(0, 8'h0C, 8'hFF, 8'h00);
    drain("drain_edges", 0);
    check("total_pkts0", 32'(pv0_cnt), 32'(exp_pv0));

    // Wheel instance: 3 bytes alone must not update; a 4-byte packet does.
    send3(1, 8'h09, 8'h05, 8'h00);
    check("wheel_3byte_noupd", 32'(pv1_cnt), 32'd0);
    repeat (1500) @(negedge clk);
    check("wheel_idle_noupd", 32'(pv1_cnt), 32'd0);
    e.x = 320; e.y = 240; e.b = 0; e.w = 15;
    q1.push_back(e);
    send3(1, 8'h08, 8'h00, 8'h00);
    check("wheel_before_4th", 32'(pv1_cnt), 32'd0);
    send_frame(1, 8'h0F, 1'b0, 11);
    drain("drain_wheel", 1);
    check("wheel_pkts", 32'(pv1_cnt), 32'd1);
    check("wheel_signed", 32'($signed(w1)), 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
